// File: rtl/partition_pkg.sv
// partition_pkg: shared types and helpers for the Lomuto partition stage.
//   - state_e       : FSM state encoding (IDLE, SCAN, FINAL, DONE)
//   - idx_width()   : index width for an N-element array
//   - elem_get/put  : element select/insert on a packed array (element k at [k*w +: w])
// The element helpers work on a wide bus so one definition serves every N/W;
// callers cast in and out at their own widths.
package partition_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned MAX_ARR_W = 1024;
    localparam int unsigned MAX_EL_W  = 64;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [MAX_ARR_W-1:0] arr_bus_t;
    typedef logic [MAX_EL_W-1:0]  elem_bus_t;

    // Index width for n elements, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n));
    endfunction

    // Read element idx of width w.
    function automatic elem_bus_t elem_get(input arr_bus_t arr, input int unsigned idx,
                                           input int unsigned w);
        elem_bus_t mask;
        mask = (elem_bus_t'(1) << w) - elem_bus_t'(1);
        return elem_bus_t'(arr >> (idx * w)) & mask;
    endfunction

    // Return arr with element idx of width w replaced by val.
    function automatic arr_bus_t elem_put(input arr_bus_t arr, input int unsigned idx,
                                          input int unsigned w, input elem_bus_t val);
        arr_bus_t mask;
        mask = ((arr_bus_t'(1) << w) - arr_bus_t'(1)) << (idx * w);
        return (arr & ~mask) | ((arr_bus_t'(val) << (idx * w)) & mask);
    endfunction

endpackage

// File: rtl/partition_fsm.sv
// partition_fsm: control for one Lomuto partition pass.
// Owns the state register, i/j scan indices, pivot capture and done/err/pivot_idx.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   start_i, lo_i, hi_i   : request and sub-range
//   pivot_i               : array_in[hi_i], captured on an accepted start
//   arr_j_i               : current register-file element at index j
//   load_c_o              : load array_in into the register file this edge
//   swap_c_o, swap_a/b_c_o: swap the two register-file elements this edge
//   j_o                   : scan index (selects arr_j_i)
//   busy_o, done_o, err_o, pidx_o : registered status outputs
module partition_fsm
    import partition_pkg::*;
#(
    parameter int unsigned  N  = 4,
    parameter int unsigned  W  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start_i,
    input  logic [IW-1:0] lo_i,
    input  logic [IW-1:0] hi_i,
    input  logic [W-1:0]  pivot_i,
    input  logic [W-1:0]  arr_j_i,
    output logic          load_c_o,
    output logic          swap_c_o,
    output logic [IW-1:0] swap_a_c_o,
    output logic [IW-1:0] swap_b_c_o,
    output logic [IW-1:0] j_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [IW-1:0] pidx_o
);

    state_e        state_q, state_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d, hi_q, hi_d, pidx_q, pidx_d;
    logic [W-1:0]  pivot_q, pivot_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

    // State and datapath-control registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            hi_q    <= '0;
            pidx_q  <= '0;
            pivot_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            hi_q    <= hi_d;
            pidx_q  <= pidx_d;
            pivot_q <= pivot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state, index updates and swap requests.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        hi_d       = hi_q;
        pidx_d     = pidx_q;
        pivot_d    = pivot_q;
        err_d      = err_q;
        done_d     = 1'b0;
        load_c_o   = 1'b0;
        swap_c_o   = 1'b0;
        swap_a_c_o = i_q;
        swap_b_c_o = j_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_c_o = 1'b1;
                    pivot_d  = pivot_i;
                    i_d      = lo_i;
                    j_d      = lo_i;
                    hi_d     = hi_i;
                    err_d    = 1'b0;
                    if ((lo_i > hi_i) || (32'(hi_i) >= N)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        pidx_d  = lo_i;
                    end else if (lo_i == hi_i) begin
                        state_d = FINAL;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                // Elements equal to the pivot go left.
                if (arr_j_i <= pivot_q) begin
                    swap_c_o = 1'b1;
                    i_d      = i_q + IW'(1);
                end
                j_d = j_q + IW'(1);
                if (j_q == hi_q - IW'(1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                swap_c_o   = 1'b1;
                swap_b_c_o = hi_q;
                pidx_d     = i_q;
                done_d     = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE);

    assign j_o    = j_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign pidx_o = pidx_q;

endmodule

// File: rtl/lomuto_partitioner.sv
// lomuto_partitioner: one Lomuto partition of sub-range [lo_ind, hi_ind] of an
// N-element, W-bit unsigned array held in an internal register file.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   start             : request, accepted only when idle
//   lo_ind, hi_ind    : sub-range; array[hi_ind] is the pivot
//   array_in          : packed input array, element k at [k*W +: W]
//   busy, done, err   : status; done is a one-cycle pulse, err valid with done
//   pivot_idx         : final pivot position
//   array_out         : register-file contents, same packing
//   swap_count        : non-trivial swaps of the last pass (PART_SWAP_CNT_EN only)
// Optional feature macro: PART_SWAP_CNT_EN.
module lomuto_partitioner
    import partition_pkg::*;
#(
    parameter int unsigned  N  = 4,
    parameter int unsigned  W  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [IW-1:0]   lo_ind,
    input  logic [IW-1:0]   hi_ind,
    input  logic [N*W-1:0]  array_in,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [IW-1:0]   pivot_idx,
    output logic [N*W-1:0]  array_out
`ifdef PART_SWAP_CNT_EN
    ,
    output logic [IW:0]     swap_count
`endif
);

    localparam int unsigned AW = N * W;

    logic [AW-1:0] arr_q, arr_d;
    logic          load_c, swap_c;
    logic [IW-1:0] swap_a_c, swap_b_c, j_idx;
    logic [W-1:0]  pivot_in_c, arr_j_c;
    elem_bus_t     va_c, vb_c;
    arr_bus_t      swapped_c;

    partition_fsm #(
        .N (N),
        .W (W)
    ) u_fsm (
        .clock      (clock),
        .reset      (reset),
        .start_i    (start),
        .lo_i       (lo_ind),
        .hi_i       (hi_ind),
        .pivot_i    (pivot_in_c),
        .arr_j_i    (arr_j_c),
        .load_c_o   (load_c),
        .swap_c_o   (swap_c),
        .swap_a_c_o (swap_a_c),
        .swap_b_c_o (swap_b_c),
        .j_o        (j_idx),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .pidx_o     (pivot_idx)
    );

    // Out-of-range hi_ind reads zero from the padded bus; that pivot is never used.
    assign pivot_in_c = W'(elem_get(arr_bus_t'(array_in), 32'(hi_ind), W));
    assign arr_j_c    = W'(elem_get(arr_bus_t'(arr_q), 32'(j_idx), W));

    // Register-file update: load on start, else exchange two elements (a == b is a no-op).
    always_comb begin
        va_c      = elem_get(arr_bus_t'(arr_q), 32'(swap_a_c), W);
        vb_c      = elem_get(arr_bus_t'(arr_q), 32'(swap_b_c), W);
        swapped_c = elem_put(elem_put(arr_bus_t'(arr_q), 32'(swap_a_c), W, vb_c),
                             32'(swap_b_c), W, va_c);
        arr_d     = arr_q;
        if (load_c) begin
            arr_d = array_in;
        end else if (swap_c) begin
            arr_d = AW'(swapped_c);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            arr_q <= '0;
        end else begin
            arr_q <= arr_d;
        end
    end

    assign array_out = arr_q;

`ifdef PART_SWAP_CNT_EN
    logic [IW:0] swap_cnt_q;

    // Counts only swaps that actually move data.
    always_ff @(posedge clock) begin
        if (reset) begin
            swap_cnt_q <= '0;
        end else if (load_c) begin
            swap_cnt_q <= '0;
        end else if (swap_c && (swap_a_c != swap_b_c)) begin
            swap_cnt_q <= swap_cnt_q + (IW+1)'(1);
        end
    end

    assign swap_count = swap_cnt_q;
`endif

endmodule

// File: tb/tb_lomuto_partitioner.sv
// Bench for lomuto_partitioner: three instances (N4/W4, N3/W4, N8/W8) share a clock
// and reset. Each request pushes a model result onto a scoreboard queue; the
// result is popped and compared when the DUT pulses done.
module tb_lomuto_partitioner;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Instance A: N=4, W=4
    logic        a_start;
    logic [1:0]  a_lo, a_hi, a_pidx;
    logic [15:0] a_in, a_arr;
    logic        a_busy, a_done, a_err;
    logic [2:0]  a_swp;
    // Instance B: N=3, W=4
    logic        b_start;
    logic [1:0]  b_lo, b_hi, b_pidx;
    logic [11:0] b_in, b_arr;
    logic        b_busy, b_done, b_err;
    logic [2:0]  b_swp;
    // Instance C: N=8, W=8
    logic        c_start;
    logic [2:0]  c_lo, c_hi, c_pidx;
    logic [63:0] c_in, c_arr;
    logic        c_busy, c_done, c_err;
    logic [3:0]  c_swp;

    lomuto_partitioner #(.N(4), .W(4)) u_dut_a (
        .clock(clock), .reset(reset), .start(a_start), .lo_ind(a_lo), .hi_ind(a_hi),
        .array_in(a_in), .busy(a_busy), .done(a_done), .err(a_err),
        .pivot_idx(a_pidx), .array_out(a_arr)
`ifdef PART_SWAP_CNT_EN
        , .swap_count(a_swp)
`endif
    );

    lomuto_partitioner #(.N(3), .W(4)) u_dut_b (
        .clock(clock), .reset(reset), .start(b_start), .lo_ind(b_lo), .hi_ind(b_hi),
        .array_in(b_in), .busy(b_busy), .done(b_done), .err(b_err),
        .pivot_idx(b_pidx), .array_out(b_arr)
`ifdef PART_SWAP_CNT_EN
        , .swap_count(b_swp)
`endif
    );

    lomuto_partitioner #(.N(8), .W(8)) u_dut_c (
        .clock(clock), .reset(reset), .start(c_start), .lo_ind(c_lo), .hi_ind(c_hi),
        .array_in(c_in), .busy(c_busy), .done(c_done), .err(c_err),
        .pivot_idx(c_pidx), .array_out(c_arr)
`ifdef PART_SWAP_CNT_EN
        , .swap_count(c_swp)
`endif
    );

`ifndef PART_SWAP_CNT_EN
    assign a_swp = '0;
    assign b_swp = '0;
    assign c_swp = '0;
`endif

    typedef struct {
        logic [63:0] arr;
        int          pidx;
        bit          err;
        int          lat;
        int          swaps;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference Lomuto partition on n elements of w bits.
    function automatic exp_t lomuto_model(input logic [63:0] a_in, input int n, input int w,
                                          input int lo, input int hi);
        exp_t        e;
        int          a[8];
        int          pv, i, t;
        logic [63:0] mask;
        mask    = (64'd1 << w) - 64'd1;
        e.arr   = a_in;
        e.pidx  = lo;
        e.err   = 1'b0;
        e.lat   = hi - lo + 2;
        e.swaps = 0;
        if (lo > hi || hi >= n) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        for (int k = 0; k < 8; k++) a[k] = (k < n) ? int'((a_in >> (k * w)) & mask) : 0;
        pv = a[hi];
        i  = lo;
        for (int j = lo; j < hi; j++) begin
            if (a[j] <= pv) begin
                if (i != j) e.swaps++;
                t = a[i]; a[i] = a[j]; a[j] = t;
                i++;
            end
        end
        if (i != hi) e.swaps++;
        t = a[i]; a[i] = a[hi]; a[hi] = t;
        e.pidx = i;
        e.arr  = '0;
        for (int k = 0; k < n; k++) e.arr |= (64'(a[k]) & mask) << (k * w);
        return e;
    endfunction

    task automatic drive(input int which, input logic [63:0] arr, input int lo, input int hi,
                         input bit s);
        case (which)
            0: begin a_start = s; a_lo = 2'(lo); a_hi = 2'(hi); a_in = 16'(arr); end
            1: begin b_start = s; b_lo = 2'(lo); b_hi = 2'(hi); b_in = 12'(arr); end
            default: begin c_start = s; c_lo = 3'(lo); c_hi = 3'(hi); c_in = arr; end
        endcase
    endtask

    task automatic sample(input int which, output logic [63:0] d, output logic [63:0] b,
                          output logic [63:0] er, output logic [63:0] pi,
                          output logic [63:0] oa, output logic [63:0] sw);
        case (which)
            0: begin d = 64'(a_done); b = 64'(a_busy); er = 64'(a_err); pi = 64'(a_pidx);
                     oa = 64'(a_arr); sw = 64'(a_swp); end
            1: begin d = 64'(b_done); b = 64'(b_busy); er = 64'(b_err); pi = 64'(b_pidx);
                     oa = 64'(b_arr); sw = 64'(b_swp); end
            default: begin d = 64'(c_done); b = 64'(c_busy); er = 64'(c_err); pi = 64'(c_pidx);
                     oa = c_arr; sw = 64'(c_swp); end
        endcase
    endtask

    // Issue one request, wait (bounded) for done, then score it.
    task automatic run(input int which, input logic [63:0] arr_in, input int lo, input int hi,
                       input bit poke, input string tag);
        int          n, w, lat;
        bit          seen;
        exp_t        e;
        logic [63:0] arr, d, b, er, pi, oa, sw;
        n   = (which == 0) ? 4 : (which == 1) ? 3 : 8;
        w   = (which == 2) ? 8 : 4;
        arr = arr_in;
        if (n * w < 64) arr &= (64'd1 << (n * w)) - 64'd1;
        sb_q.push_back(lomuto_model(arr, n, w, lo, hi));
        @(negedge clock);
        drive(which, arr, lo, hi, 1'b1);
        seen = 1'b0;
        lat  = 0;
        // Iteration m observes the outputs after edge m (edge 0 accepts start).
        for (int m = 0; m < 40 && !seen; m++) begin
            @(negedge clock);
            sample(which, d, b, er, pi, oa, sw);
            if (d[0]) begin
                seen = 1'b1;
                lat  = m + 1;
            end else begin
                check_eq({tag, "_busy"}, b, 64'd1);
            end
            if (m == 0) drive(which, arr, lo, hi, 1'b0);
            if (poke && m == 1) drive(which, ~arr, 0, n - 1, 1'b1);
            if (poke && m == 2) drive(which, arr, lo, hi, 1'b0);
        end
        if (!seen) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
        e = sb_q.pop_front();
        check_eq({tag, "_arr"}, oa, e.arr);
        check_eq({tag, "_pidx"}, pi, 64'(e.pidx));
        check_eq({tag, "_err"}, er, 64'(e.err));
        check_eq({tag, "_lat"}, 64'(lat), 64'(e.lat));
`ifdef PART_SWAP_CNT_EN
        check_eq({tag, "_swaps"}, sw, 64'(e.swaps));
`endif
        @(negedge clock);
        sample(which, d, b, er, pi, oa, sw);
        check_eq({tag, "_done_pulse"}, d, 64'd0);
        check_eq({tag, "_idle"}, b, 64'd0);
    endtask

    initial begin
        logic [63:0] d, b, er, pi, oa, sw, ra;
        int          lo, hi;
        drive(0, 64'd0, 0, 0, 1'b0);
        drive(1, 64'd0, 0, 0, 1'b0);
        drive(2, 64'd0, 0, 0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            sample(k, d, b, er, pi, oa, sw);
            check_eq("rst_done", d, 64'd0);
            check_eq("rst_busy", b, 64'd0);
            check_eq("rst_err", er, 64'd0);
            check_eq("rst_pidx", pi, 64'd0);
            check_eq("rst_arr", oa, 64'd0);
        end
        reset = 1'b0;

        run(0, 64'h2413, 0, 3, 1'b0, "full");
        check_eq("full_literal", 64'(a_arr), 64'h3421);
        run(0, 64'h4321, 0, 3, 1'b0, "sorted");
        run(0, 64'h2222, 0, 3, 1'b0, "equal");
        run(0, 64'h0359, 1, 2, 1'b0, "subrange");
        check_eq("subrange_literal", 64'(a_arr), 64'h0539);
        run(0, 64'h0359, 2, 2, 1'b0, "single");
        run(0, 64'h2413, 3, 1, 1'b0, "err_lohi");
        run(1, 64'h321, 0, 3, 1'b0, "err_hiN");
        run(0, 64'h2413, 0, 3, 1'b1, "poke");

        // Reset on edge 2 of a running pass aborts it without a done pulse.
        @(negedge clock);
        drive(0, 64'h2413, 0, 3, 1'b1);
        @(negedge clock);
        drive(0, 64'h2413, 0, 3, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sample(0, d, b, er, pi, oa, sw);
        check_eq("abort_done", d, 64'd0);
        check_eq("abort_busy", b, 64'd0);
        check_eq("abort_pidx", pi, 64'd0);
        check_eq("abort_arr", oa, 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            sample(0, d, b, er, pi, oa, sw);
            check_eq("abort_nodone", d, 64'd0);
        end
        run(0, 64'h1342, 0, 3, 1'b0, "after_abort");

        for (int r = 0; r < 24; r++) begin
            if (r % 3 == 0) begin
                ra = '0;
                for (int k = 0; k < 8; k++) ra |= 64'($urandom_range(0, 3)) << (k * 8);
            end else begin
                ra = {$urandom, $urandom};
            end
            lo = int'($urandom_range(0, 7));
            hi = (r % 8 == 7) ? int'($urandom_range(0, 7)) : int'($urandom_range(lo, 7));
            run(2, ra, lo, hi, 1'b0, "rand");
        end
        run(2, 64'h0102030405060708, 0, 7, 1'b0, "rev8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lomuto_partitioner.md
Name: lomuto_partitioner

Overview:
- Parametrised, handshaked successor of the 4-element partition stage. Performs one complete Lomuto partition of sub-range [lo_ind, hi_ind] of an N-element, W-bit unsigned array held in an internal register file.
- Pivot is array[hi_ind]. Returns the partitioned array and the final pivot index.
- Called repeatedly by the quicksort controller, which owns the recursion stack and feeds sub-ranges back in.

Parameters:
- N, 4: number of array elements, N >= 2
- W, 4: element width in bits, W >= 1
- IW, $clog2(N): index width (derived, not to be overridden)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- lo_ind  in  IW  low index of sub-range
- hi_ind  in  IW  high index of sub-range; its element is the pivot
- array_in  in  N*W  packed array; element k at [k*W +: W]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  range-error flag; valid while done=1
- pivot_idx  out  IW  final pivot position; valid from done until next start
- array_out  out  N*W  partitioned array, same packing; held until next start
- swap_count  out  IW+1  only with PART_SWAP_CNT_EN

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; busy, done, err = 0; pivot_idx = 0.
  - array_out all zero; internal i, j, pivot = 0.
  - A reset asserted mid-operation aborts the operation; no done is issued.
- FSM states: IDLE, SCAN, FINAL, DONE.
- IDLE:
  - start=1 at edge 0 loads array_in into the register file and captures pivot = array_in[hi_ind], i = lo_ind, j = lo_ind.
  - Next state is SCAN if lo_ind < hi_ind, FINAL if lo_ind == hi_ind.
  - Next state is DONE with err=1 if lo_ind > hi_ind or hi_ind >= N; in this case the array is loaded unchanged and pivot_idx = lo_ind.
- SCAN: one element per edge.
  - If arr[j] <= pivot (unsigned): swap arr[i] and arr[j], then i = i+1.
  - Then j = j+1. After processing j = hi_ind-1, go to FINAL.
- FINAL: swap arr[i] and arr[hi_ind]; pivot_idx = i; go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - start is not accepted in DONE; it is accepted again from IDLE on the following edge.
- Latency:
  - Valid range: done is sampled high at edge hi-lo+2 after the start edge. Full N=4 range gives 5.
  - Error path: done is sampled high at edge 1.
- Throughput: one partition in flight. start while busy is ignored and not queued.
- Elements outside [lo, hi] are never modified.
- A swap with i == j is a legal self-swap and leaves data unchanged.
- Duplicates equal to the pivot go to the left partition (<= comparison).
- i never exceeds hi_ind and j never wraps; both are IW wide with no overflow for legal ranges.
- array_out continuously reflects the register file. It is only guaranteed partitioned while done=1 and afterwards until the next start.

Optional Feature:
- Macro: PART_SWAP_CNT_EN.
- Defined:
  - Adds output swap_count, cleared on accepted start.
  - Increments on every SCAN swap with i != j and on the FINAL swap if i != hi_ind.
  - Valid with done; reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package partition_pkg holds:
  - state encoding localparams (IDLE, SCAN, FINAL, DONE);
  - index-width helper function;
  - packed-array element select/insert functions.
- One natural sub-module, partition_fsm: state register, i/j counters, pivot capture, done/err generation.
- The register file and swap datapath stay in lomuto_partitioner.

Test Plan:
- N=4, W=4, array {3,1,4,2} (element 0 first), lo=0, hi=3 -> array_out {1,2,4,3}, pivot_idx=1, done at edge 5, busy high edges 1-4, swap_count=2.
- Sorted {1,2,3,4}, lo=0, hi=3 -> array unchanged, pivot_idx=3, swap_count=0. All-equal {2,2,2,2} -> pivot_idx=3, unchanged.
- Sub-range {9,5,3,0}, lo=1, hi=2 -> {9,3,5,0}, pivot_idx=1, elements 0 and 3 untouched, done at edge 3. lo=hi=2 -> unchanged, pivot_idx=2, done at edge 2.
- Error: lo=3, hi=1 -> done with err=1 at edge 1, array_out = array_in, pivot_idx=3. Repeat with hi>=N (N=3 build, hi=3) -> same err response.
- start pulsed during SCAN with different data -> ignored, result matches first request. Reset asserted on edge 2 -> all outputs zero, no done pulse; a new start afterwards completes normally.
- N=8, W=8 random arrays and ranges vs. golden Lomuto model -> exact array and pivot_idx match. Latency equals hi-lo+2 in every case.
